mqnic_tx_req_arb: RTL
=====================

Name: mqnic_tx_req_arb

Overview:
Shares one TX engine request port between SCHED_COUNT TX scheduler blocks.
- Arbitrates transmit requests round-robin.
- Prefixes each outgoing tag with the source scheduler index.
- Routes each engine completion status back to the scheduler that issued the request.
- Optionally caps outstanding requests per scheduler, so one busy scheduler cannot fill the engine's op table.

Parameters:
SCHED_COUNT, 4, number of scheduler requesters (power of 2, >=2)
QUEUE_INDEX_WIDTH, 13, queue index width
REQ_TAG_WIDTH, 8, per-scheduler tag width
AXIS_TX_DEST_WIDTH, 5, dest field width
DMA_LEN_WIDTH, 16, status length width
CL_SCHED, $clog2(SCHED_COUNT), index width (derived)
M_REQ_TAG_WIDTH, REQ_TAG_WIDTH+CL_SCHED, engine-side tag width (derived)
MAX_INFLIGHT, 16, per-scheduler outstanding request limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axis_tx_req_queue  in  SCHED_COUNT*QUEUE_INDEX_WIDTH  per-scheduler queue index
s_axis_tx_req_tag  in  SCHED_COUNT*REQ_TAG_WIDTH  per-scheduler tag
s_axis_tx_req_dest  in  SCHED_COUNT*AXIS_TX_DEST_WIDTH  per-scheduler dest
s_axis_tx_req_valid  in  SCHED_COUNT  request valid
s_axis_tx_req_ready  out  SCHED_COUNT  request ready
m_axis_tx_req_queue  out  QUEUE_INDEX_WIDTH  to engine
m_axis_tx_req_tag  out  M_REQ_TAG_WIDTH  {source index, source tag}
m_axis_tx_req_dest  out  AXIS_TX_DEST_WIDTH  to engine
m_axis_tx_req_valid  out  1  to engine
m_axis_tx_req_ready  in  1  from engine
s_axis_tx_req_status_len  in  DMA_LEN_WIDTH  engine status length
s_axis_tx_req_status_tag  in  M_REQ_TAG_WIDTH  engine status tag
s_axis_tx_req_status_valid  in  1  engine status strobe
m_axis_tx_req_status_len  out  DMA_LEN_WIDTH  broadcast to all schedulers
m_axis_tx_req_status_tag  out  REQ_TAG_WIDTH  low tag bits
m_axis_tx_req_status_valid  out  SCHED_COUNT  one-hot strobe

Behaviour:
Reset:
- All outputs 0.
- Round-robin pointer = 0.
- In-flight counters = 0.
- Reset mid-transfer discards the held request and any pending status.

Eligibility and grant:
- Scheduler i is eligible when valid[i] is high (and, with the feature enabled, inflight[i] < MAX_INFLIGHT).
- Output stage is a single register slice. It loads when !m_valid || m_ready.
- Grant goes to the first eligible index at or after the pointer, wrapping from SCHED_COUNT-1 to 0.
- s_ready[grant] is combinational: it is high only when the slice can load and a grant exists. At most one ready bit is high per cycle.

Transfer and latency:
- On the s handshake in cycle N, the slice captures queue, dest and tag = {i, s_tag[i]}. m_valid is high from cycle N+1.
- The pointer becomes i+1 mod SCHED_COUNT on each handshake. With no handshake, the pointer holds.
- m_* outputs are stable while m_valid && !m_ready.
- Back-to-back requests give one per cycle while m_ready stays high.

Status return:
- Registered with 1-cycle latency.
- Index j = status_tag[M_REQ_TAG_WIDTH-1 -: CL_SCHED].
- Outputs: status_valid[j] = 1, status_tag = low REQ_TAG_WIDTH bits, len passed through.
- Status is accepted every cycle; there is no backpressure.

Optional Feature:
Macro: MQNIC_TX_REQ_ARB_INFLIGHT_LIMIT_EN
- Defined:
  - A $clog2(MAX_INFLIGHT+1)-bit counter per scheduler.
  - +1 on that scheduler's s handshake; -1 on a status with index j.
  - Increment and decrement in the same cycle on the same counter: counter unchanged.
  - Decrement at 0 saturates at 0.
  - A scheduler whose counter equals MAX_INFLIGHT is skipped by the arbiter until its count drops.
- Undefined:
  - No counters are instantiated.
  - Eligibility = valid only.
  - MAX_INFLIGHT is ignored.

Test Plan:
1. SCHED_COUNT=4; valid=4'b1111 held; m_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3. m_tag[9:8] follows the same sequence. The first m_valid appears 1 cycle after the first handshake.
2. valid=4'b0101, pointer=1 -> grant 2, then 0, then 2. s_ready is never high for index 1 or 3.
3. m_ready=0 for 5 cycles with m_valid=1 (queue=0x123, tag=0x2A5) -> outputs held constant. All s_ready low. Pointer unchanged.
4. Status tag=0x3A7, len=1500 -> next cycle: status_valid=4'b1000, status_tag=0xA7, len=1500. No other strobes.
5. Feature on, MAX_INFLIGHT=2: scheduler 0 alone valid, no status -> exactly 2 handshakes, then ready stays low. Status tag=0x0xx -> one further handshake allowed.
6. Feature on: scheduler 1 handshake and status for index 1 in the same cycle with counter=1 -> counter stays 1. Assert rst mid-stream -> m_valid=0, status_valid=0, counters=0 immediately.

Source files
------------

// File: rtl/mqnic_tx_req_arb.sv
// Round-robin arbiter sharing one TX engine request port between SCHED_COUNT schedulers.
// Define MQNIC_TX_REQ_ARB_INFLIGHT_LIMIT_EN to cap outstanding requests per scheduler at MAX_INFLIGHT.
module mqnic_tx_req_arb #(
   parameter int SCHED_COUNT        = 4,
   parameter int QUEUE_INDEX_WIDTH  = 13,
   parameter int REQ_TAG_WIDTH      = 8,
   parameter int AXIS_TX_DEST_WIDTH = 5,
   parameter int DMA_LEN_WIDTH      = 16,
   parameter int CL_SCHED           = $clog2(SCHED_COUNT),
   parameter int M_REQ_TAG_WIDTH    = REQ_TAG_WIDTH + CL_SCHED,
   parameter int MAX_INFLIGHT       = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,

   input  logic [SCHED_COUNT*QUEUE_INDEX_WIDTH-1:0]  s_axis_tx_req_queue,
   input  logic [SCHED_COUNT*REQ_TAG_WIDTH-1:0]      s_axis_tx_req_tag,
   input  logic [SCHED_COUNT*AXIS_TX_DEST_WIDTH-1:0] s_axis_tx_req_dest,
   input  logic [SCHED_COUNT-1:0]                    s_axis_tx_req_valid,
   output logic [SCHED_COUNT-1:0]                    s_axis_tx_req_ready,

   output logic [QUEUE_INDEX_WIDTH-1:0]              m_axis_tx_req_queue,
   output logic [M_REQ_TAG_WIDTH-1:0]                m_axis_tx_req_tag,
   output logic [AXIS_TX_DEST_WIDTH-1:0]             m_axis_tx_req_dest,
   output logic                                      m_axis_tx_req_valid,
   input  logic                                      m_axis_tx_req_ready,

   input  logic [DMA_LEN_WIDTH-1:0]                  s_axis_tx_req_status_len,
   input  logic [M_REQ_TAG_WIDTH-1:0]                s_axis_tx_req_status_tag,
   input  logic                                      s_axis_tx_req_status_valid,

   output logic [DMA_LEN_WIDTH-1:0]                  m_axis_tx_req_status_len,
   output logic [REQ_TAG_WIDTH-1:0]                  m_axis_tx_req_status_tag,
   output logic [SCHED_COUNT-1:0]                    m_axis_tx_req_status_valid
);

   if (SCHED_COUNT < 2 || (SCHED_COUNT & (SCHED_COUNT - 1)) != 0 || MAX_INFLIGHT < 1) begin : g_paramCheck
      $error("mqnic_tx_req_arb: SCHED_COUNT must be a power of 2 >= 2 and MAX_INFLIGHT >= 1");
   end

   logic [CL_SCHED-1:0]           r_ptr;
   logic                          r_mValid;
   logic [QUEUE_INDEX_WIDTH-1:0]  r_mQueue;
   logic [M_REQ_TAG_WIDTH-1:0]    r_mTag;
   logic [AXIS_TX_DEST_WIDTH-1:0] r_mDest;

   logic [DMA_LEN_WIDTH-1:0]      r_statusLen;
   logic [REQ_TAG_WIDTH-1:0]      r_statusTag;
   logic [SCHED_COUNT-1:0]        r_statusValid;

   logic [SCHED_COUNT-1:0]        w_eligible;
   logic                          w_grantValid;
   logic [CL_SCHED-1:0]           w_grantIdx;
   logic                          w_load;
   logic                          w_handshake;
   logic [QUEUE_INDEX_WIDTH-1:0]  w_selQueue;
   logic [REQ_TAG_WIDTH-1:0]      w_selTag;
   logic [AXIS_TX_DEST_WIDTH-1:0] w_selDest;
   logic [CL_SCHED-1:0]           w_statusIdx;
   logic [SCHED_COUNT-1:0]        w_statusOneHot;

   // Scan from the highest offset down so the candidate nearest the pointer is the last one written.
   always_comb begin
      logic [CL_SCHED-1:0] cand;
      w_grantValid = 1'b0;
      w_grantIdx   = '0;
      cand         = '0;
      for (int k = SCHED_COUNT - 1; k >= 0; k--) begin
         cand = r_ptr + CL_SCHED'(k);
         if (w_eligible[cand]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = cand;
         end
      end
   end

   assign w_load      = !r_mValid || m_axis_tx_req_ready;
   assign w_handshake = w_load && w_grantValid;

   always_comb begin
      s_axis_tx_req_ready = '0;
      if (w_handshake) begin
         s_axis_tx_req_ready[w_grantIdx] = 1'b1;
      end
   end

   assign w_selQueue = s_axis_tx_req_queue[w_grantIdx*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
   assign w_selTag   = s_axis_tx_req_tag[w_grantIdx*REQ_TAG_WIDTH +: REQ_TAG_WIDTH];
   assign w_selDest  = s_axis_tx_req_dest[w_grantIdx*AXIS_TX_DEST_WIDTH +: AXIS_TX_DEST_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr    <= '0;
         r_mValid <= 1'b0;
         r_mQueue <= '0;
         r_mTag   <= '0;
         r_mDest  <= '0;
      end else begin
         if (w_load) begin
            r_mValid <= w_grantValid;
         end
         if (w_handshake) begin
            r_mQueue <= w_selQueue;
            r_mTag   <= {w_grantIdx, w_selTag};
            r_mDest  <= w_selDest;
            r_ptr    <= w_grantIdx + CL_SCHED'(1);
         end
      end
   end

   assign m_axis_tx_req_queue = r_mQueue;
   assign m_axis_tx_req_tag   = r_mTag;
   assign m_axis_tx_req_dest  = r_mDest;
   assign m_axis_tx_req_valid = r_mValid;

   // Source index rides in the top tag bits and selects which scheduler gets the status strobe.
   assign w_statusIdx = s_axis_tx_req_status_tag[M_REQ_TAG_WIDTH-1 -: CL_SCHED];

   always_comb begin
      w_statusOneHot = '0;
      if (s_axis_tx_req_status_valid) begin
         w_statusOneHot[w_statusIdx] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_statusLen   <= '0;
         r_statusTag   <= '0;
         r_statusValid <= '0;
      end else begin
         r_statusValid <= w_statusOneHot;
         if (s_axis_tx_req_status_valid) begin
            r_statusLen <= s_axis_tx_req_status_len;
            r_statusTag <= s_axis_tx_req_status_tag[REQ_TAG_WIDTH-1:0];
         end
      end
   end

   assign m_axis_tx_req_status_len   = r_statusLen;
   assign m_axis_tx_req_status_tag   = r_statusTag;
   assign m_axis_tx_req_status_valid = r_statusValid;

`ifdef MQNIC_TX_REQ_ARB_INFLIGHT_LIMIT_EN
   localparam int CW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

   // A simultaneous issue and completion on one scheduler cancel out.
   for (genvar g = 0; g < SCHED_COUNT; g++) begin : g_inflight
      logic [CW-1:0] r_inflight;
      logic          w_inc;
      logic          w_dec;

      assign w_inc = w_handshake && (w_grantIdx == CL_SCHED'(g));
      assign w_dec = w_statusOneHot[g];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_inflight <= '0;
         end else if (w_inc && !w_dec) begin
            r_inflight <= r_inflight + CW'(1);
         end else if (w_dec && !w_inc && r_inflight != '0) begin
            r_inflight <= r_inflight - CW'(1);
         end
      end

      assign w_eligible[g] = s_axis_tx_req_valid[g] && (r_inflight < MAX_CNT);
   end
`else
   assign w_eligible = s_axis_tx_req_valid;
`endif

endmodule
